// File: rtl/decode8seq_pkg.sv
// Shared types and opcode constants for the decode8seq instruction sequencer.
package decode8seq_pkg;

  typedef enum logic [3:0] {
    CLS_TA = 4'b0001,
    CLS_MV = 4'b0010,
    CLS_AL = 4'b0100,
    CLS_SC = 4'b1000
  } cls_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [7:0] HLT  = 8'h76;
  localparam logic [7:0] CALL = 8'hCD;
  localparam logic [7:0] RET  = 8'hC9;
  localparam logic [7:0] JMP  = 8'hC3;
  localparam logic [7:0] XTHL = 8'hE3;
  localparam logic [7:0] LDA  = 8'h3A;
  localparam logic [7:0] STA  = 8'h32;
  localparam logic [7:0] LHLD = 8'h2A;
  localparam logic [7:0] SHLD = 8'h22;
  localparam logic [7:0] IN   = 8'hDB;
  localparam logic [7:0] OUT  = 8'hD3;
  localparam logic [7:0] RIM  = 8'h20;
  localparam logic [7:0] SIM  = 8'h30;

  localparam logic [2:0] FLD_M = 3'b110;

  function automatic cls_e cls_of(input logic [7:0] op);
    case (op[7:6])
      2'b00:   cls_of = CLS_TA;
      2'b01:   cls_of = CLS_MV;
      2'b10:   cls_of = CLS_AL;
      default: cls_of = CLS_SC;
    endcase
  endfunction

endpackage

// File: rtl/decode8seq_if.sv
// Handshake bundle between the bus/timing unit and the decode8seq sequencer.
interface decode8seq_if #(
  parameter int MCW = 3
);
  logic [7:0]     inDI;
  logic           iFETCH;
  logic           iMDONE;
  logic           iCOND;
  logic           iINTR;
  logic [3:0]     oCLS;
  logic           oLD;
  logic           oHD;
  logic [MCW-1:0] oM;
  logic [MCW-1:0] oMIDX;
  logic           oBUSY;
  logic           oLAST;
  logic           oHALT;
  logic           oEXT;

  modport master (
    output inDI, iFETCH, iMDONE, iCOND, iINTR,
    input  oCLS, oLD, oHD, oM, oMIDX, oBUSY, oLAST, oHALT, oEXT
  );

  modport slave (
    input  inDI, iFETCH, iMDONE, iCOND, iINTR,
    output oCLS, oLD, oHD, oM, oMIDX, oBUSY, oLAST, oHALT, oEXT
  );
endinterface

// File: rtl/decode8cnt.sv
// Combinational opcode decoder: class, M/H fields, 8085 machine-cycle count
// and conditional-termination check cycle.
module decode8cnt
  import decode8seq_pkg::*;
#(
  parameter int MCW     = 3,
  parameter int MAXM    = 5,
  parameter int EXT8085 = 1
) (
  input  logic [7:0]     i_op,
  output cls_e           o_cls,
  output logic           o_ld,
  output logic           o_hd,
  output logic [MCW-1:0] o_cnt,
  output logic           o_cond,
  output logic [MCW-1:0] o_chk,
  output logic           o_ext
);

  logic        w_ld;
  logic        w_hd;
  logic [31:0] w_raw;

  assign w_ld = (i_op[2:0] == FLD_M);
  assign w_hd = (i_op[5:3] == FLD_M);

  always_comb begin
    w_raw  = 32'd1;
    o_cond = 1'b0;
    o_chk  = '0;
    case (i_op[7:6])
      2'b01: begin
        if (i_op == HLT)     w_raw = 32'd2;
        else if (w_ld ^ w_hd) w_raw = 32'd2;
      end
      2'b10: begin
        if (w_ld) w_raw = 32'd2;
      end
      2'b00: begin
        if (i_op == 8'h36 || i_op == 8'h34 || i_op == 8'h35) w_raw = 32'd3;
        else if (i_op == LDA || i_op == STA)                 w_raw = 32'd4;
        else if (i_op == LHLD || i_op == SHLD)               w_raw = 32'd5;
        else if (i_op[3:0] == 4'b0001)                       w_raw = 32'd3;
        else if (i_op[3:0] == 4'b1001)                       w_raw = 32'd3;
        else if (i_op == 8'h02 || i_op == 8'h12 ||
                 i_op == 8'h0A || i_op == 8'h1A)             w_raw = 32'd2;
        else if (w_ld)                                       w_raw = 32'd2;
      end
      default: begin
        if (i_op == JMP)                     w_raw = 32'd3;
        else if (i_op == CALL)               w_raw = 32'd5;
        else if (i_op == RET)                w_raw = 32'd3;
        else if (i_op == XTHL)               w_raw = 32'd5;
        else if (i_op == IN || i_op == OUT)  w_raw = 32'd3;
        else if (i_op[3:0] == 4'b0101)       w_raw = 32'd3;
        else if (i_op[3:0] == 4'b0001)       w_raw = 32'd3;
        else if (i_op[2:0] == 3'b111)        w_raw = 32'd3;
        else if (i_op[2:0] == 3'b010) begin
          w_raw  = 32'd3;
          o_cond = 1'b1;
          o_chk  = MCW'(2);
        end else if (i_op[2:0] == 3'b100) begin
          w_raw  = 32'd5;
          o_cond = 1'b1;
          o_chk  = MCW'(2);
        end else if (i_op[2:0] == 3'b000) begin
          // Rcc decides on the opcode fetch cycle itself
          w_raw  = 32'd3;
          o_cond = 1'b1;
          o_chk  = MCW'(1);
        end else if (w_ld)                   w_raw = 32'd2;
      end
    endcase
  end

  assign o_cls = cls_of(i_op);
  assign o_ld  = w_ld;
  assign o_hd  = w_hd;
  assign o_cnt = (w_raw > 32'(MAXM)) ? MCW'(MAXM) : MCW'(w_raw);
  assign o_ext = (EXT8085 != 0) && (i_op == RIM || i_op == SIM);

endmodule

// File: rtl/decode8seq.sv
// Opcode latch and machine-cycle sequencer; steps oMIDX in handshake with the
// bus unit, handles conditional early exit and the halt state.
module decode8seq
  import decode8seq_pkg::*;
#(
  parameter int MCW     = 3,
  parameter int MAXM    = 5,
  parameter int EXT8085 = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  decode8seq_if.slave bus
);

  logic [7:0]     r_op;
  state_e         r_state;
  state_e         w_state_nxt;
  logic [MCW-1:0] r_midx;
  logic [MCW-1:0] w_midx_nxt;
  logic [MCW-1:0] r_m;
  logic [MCW-1:0] r_chk;
  cls_e           r_cls;
  logic           r_ld;
  logic           r_hd;
  logic           r_cond;
  logic           r_ext;
  logic           w_load;
  logic           w_last;

  cls_e           w_cls;
  logic           w_ld;
  logic           w_hd;
  logic [MCW-1:0] w_cnt;
  logic           w_cond;
  logic [MCW-1:0] w_chk;
  logic           w_ext;

  decode8cnt #(
    .MCW     (MCW),
    .MAXM    (MAXM),
    .EXT8085 (EXT8085)
  ) u_cnt (
    .i_op   (bus.inDI),
    .o_cls  (w_cls),
    .o_ld   (w_ld),
    .o_hd   (w_hd),
    .o_cnt  (w_cnt),
    .o_cond (w_cond),
    .o_chk  (w_chk),
    .o_ext  (w_ext)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_op    <= '0;
      r_state <= IDLE;
      r_midx  <= '0;
      r_cls   <= CLS_TA;
      r_ld    <= 1'b0;
      r_hd    <= 1'b0;
      r_m     <= MCW'(1);
      r_cond  <= 1'b0;
      r_chk   <= '0;
      r_ext   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_midx  <= w_midx_nxt;
      // Decode is captured with the opcode, so it only changes on an accepted fetch
      if (w_load) begin
        r_op   <= bus.inDI;
        r_cls  <= w_cls;
        r_ld   <= w_ld;
        r_hd   <= w_hd;
        r_m    <= w_cnt;
        r_cond <= w_cond;
        r_chk  <= w_chk;
        r_ext  <= w_ext;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_midx_nxt  = r_midx;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        w_midx_nxt = '0;
        if (bus.iFETCH) begin
          w_load      = 1'b1;
          w_midx_nxt  = MCW'(1);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_last = (r_midx == r_m) ||
                 (r_cond && (r_midx == r_chk) && !bus.iCOND);
        if (bus.iMDONE) begin
          if (!w_last) begin
            w_midx_nxt = r_midx + MCW'(1);
          end else if (r_op == HLT) begin
            w_midx_nxt  = '0;
            w_state_nxt = HALTED;
          end else if (bus.iFETCH) begin
            w_load      = 1'b1;
            w_midx_nxt  = MCW'(1);
            w_state_nxt = RUN;
          end else begin
            w_midx_nxt  = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      HALTED: begin
        w_midx_nxt = '0;
        if (bus.iINTR) w_state_nxt = IDLE;
      end
      default: begin
        w_midx_nxt  = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.oCLS  = r_cls;
  assign bus.oLD   = r_ld;
  assign bus.oHD   = r_hd;
  assign bus.oM    = r_m;
  assign bus.oMIDX = r_midx;
  assign bus.oBUSY = (r_state == RUN);
  assign bus.oLAST = w_last;
  assign bus.oHALT = (r_state == HALTED);
  assign bus.oEXT  = r_ext;

endmodule

// File: tb/tb_decode8seq.sv
// Scoreboard bench for decode8seq: directed opcode sequences on an 8085-mode
// and an 8080-mode instance driven with identical stimulus.
module tb_decode8seq;

  logic CLK;
  logic nRST;

  decode8seq_if #(.MCW(3)) if0 ();
  decode8seq_if #(.MCW(3)) if1 ();

  decode8seq #(.MCW(3), .MAXM(5), .EXT8085(1)) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (if0)
  );

  decode8seq #(.MCW(3), .MAXM(5), .EXT8085(0)) u_dut8080 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (if1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        sel;
    logic [15:0] v;
  } exp_t;

  exp_t q[$];
  int   ntests;
  int   nfail;
  logic chk;
  logic done;
  logic done_seen;

  // Expected decode fields held between instructions
  logic [3:0] e_cls;
  logic       e_ld;
  logic       e_hd;
  logic       e_ext;
  logic [2:0] e_m;
  logic       e_sel;

  exp_t        m_e;
  logic [15:0] m_act;

  initial begin
    ntests    = 0;
    nfail     = 0;
    done_seen = 1'b0;
  end

  always @(negedge CLK) begin
    if (chk) begin
      ntests++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL scoreboard_underflow: got empty queue, required an entry");
      end else begin
        m_e   = q.pop_front();
        m_act = m_e.sel ?
          {if1.oCLS, if1.oLD, if1.oHD, if1.oEXT, if1.oM, if1.oMIDX, if1.oBUSY, if1.oLAST, if1.oHALT} :
          {if0.oCLS, if0.oLD, if0.oHD, if0.oEXT, if0.oM, if0.oMIDX, if0.oBUSY, if0.oLAST, if0.oHALT};
        if (m_act !== m_e.v) begin
          nfail++;
          $display("FAIL %s: got cls/ld/hd/ext/m/midx/busy/last/halt=%b required %b",
                   m_e.nm, m_act, m_e.v);
        end
      end
    end else if (done && !done_seen) begin
      done_seen = 1'b1;
      ntests++;
      if (q.size() != 0) begin
        nfail++;
        $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
      end
    end
  end

  task automatic dec(input logic [3:0] c, input logic l, input logic h,
                     input logic x, input logic [2:0] m);
    e_cls = c;
    e_ld  = l;
    e_hd  = h;
    e_ext = x;
    e_m   = m;
  endtask

  task automatic step(input string nm, input logic f, input logic [7:0] d,
                      input logic md, input logic c, input logic intr,
                      input logic [2:0] midx, input logic bsy,
                      input logic lst, input logic hlt);
    exp_t e;
    if0.iFETCH = f;  if0.inDI = d; if0.iMDONE = md; if0.iCOND = c; if0.iINTR = intr;
    if1.iFETCH = f;  if1.inDI = d; if1.iMDONE = md; if1.iCOND = c; if1.iINTR = intr;
    e.nm  = nm;
    e.sel = e_sel;
    e.v   = {e_cls, e_ld, e_hd, e_ext, e_m, midx, bsy, lst, hlt};
    q.push_back(e);
    chk = 1'b1;
    @(posedge CLK);
    #1;
    chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    chk   = 1'b0;
    done  = 1'b0;
    e_sel = 1'b0;
    nRST  = 1'b0;
    if0.iFETCH = 1'b0; if0.inDI = '0; if0.iMDONE = 1'b0; if0.iCOND = 1'b0; if0.iINTR = 1'b0;
    if1.iFETCH = 1'b0; if1.inDI = '0; if1.iMDONE = 1'b0; if1.iCOND = 1'b0; if1.iINTR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    dec(4'b0001, 0, 0, 0, 3'd1);
    step("reset", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // MOV B,A
    step("mov_fetch", 1, 8'h47, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b0010, 0, 0, 0, 3'd1);
    step("mov_m1",   0, 8'h00, 1, 0, 0, 3'd1, 1, 1, 0);
    step("mov_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // LHLD with a stall and an ignored mid-instruction fetch
    step("lhld_fetch", 1, 8'h2A, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b0001, 0, 0, 0, 3'd5);
    step("lhld_m1",        0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("lhld_hold",      0, 8'h00, 0, 0, 0, 3'd2, 1, 0, 0);
    step("lhld_m2",        0, 8'h00, 1, 0, 0, 3'd2, 1, 0, 0);
    step("lhld_fetch_ign", 1, 8'h00, 0, 0, 0, 3'd3, 1, 0, 0);
    step("lhld_m3",        0, 8'h00, 1, 0, 0, 3'd3, 1, 0, 0);
    step("lhld_m4",        0, 8'h00, 1, 0, 0, 3'd4, 1, 0, 0);
    step("lhld_m5",        0, 8'h00, 1, 0, 0, 3'd5, 1, 1, 0);
    step("lhld_idle",      0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // CZ, condition false at M2
    step("cz0_fetch", 1, 8'hCC, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b1000, 0, 0, 0, 3'd5);
    step("cz0_m1",   0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("cz0_m2",   0, 8'h00, 1, 0, 0, 3'd2, 1, 1, 0);
    step("cz0_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // CZ, condition true at M2 (false at M1 is don't-care)
    step("cz1_fetch", 1, 8'hCC, 0, 0, 0, 3'd0, 0, 0, 0);
    step("cz1_m1",   0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("cz1_m2",   0, 8'h00, 1, 1, 0, 3'd2, 1, 0, 0);
    step("cz1_m3",   0, 8'h00, 1, 0, 0, 3'd3, 1, 0, 0);
    step("cz1_m4",   0, 8'h00, 1, 0, 0, 3'd4, 1, 0, 0);
    step("cz1_m5",   0, 8'h00, 1, 0, 0, 3'd5, 1, 1, 0);
    step("cz1_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // RZ, condition false at M1
    step("rz_fetch", 1, 8'hC8, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b1000, 0, 0, 0, 3'd3);
    step("rz_m1",   0, 8'h00, 1, 0, 0, 3'd1, 1, 1, 0);
    step("rz_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // HLT, then fetch/mdone ignored, interrupt exits
    step("hlt_fetch", 1, 8'h76, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b0010, 1, 1, 0, 3'd2);
    step("hlt_m1",        0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("hlt_m2",        0, 8'h00, 1, 0, 0, 3'd2, 1, 1, 0);
    step("hlt_fetch_ign", 1, 8'h47, 1, 0, 0, 3'd0, 0, 0, 1);
    step("hlt_intr",      0, 8'h00, 0, 0, 1, 3'd0, 0, 0, 1);
    step("hlt_exit",      0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // LXI H then back-to-back MVI A
    step("lxi_fetch", 1, 8'h21, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b0001, 0, 0, 0, 3'd3);
    step("lxi_m1",     0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("lxi_m2",     0, 8'h00, 1, 0, 0, 3'd2, 1, 0, 0);
    step("lxi_m3_b2b", 1, 8'h3E, 1, 0, 0, 3'd3, 1, 1, 0);
    dec(4'b0001, 1, 0, 0, 3'd2);
    step("mvi_m1",   0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("mvi_m2",   0, 8'h00, 1, 0, 0, 3'd2, 1, 1, 0);
    step("mvi_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);

    // RIM: flagged on the 8085 instance, plain NOP on the 8080 instance
    step("rim_fetch", 1, 8'h20, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b0001, 0, 0, 1, 3'd1);
    step("rim_m1",   0, 8'h00, 1, 0, 0, 3'd1, 1, 1, 0);
    step("rim_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);
    e_sel = 1'b1;
    e_ext = 1'b0;
    step("rim_8080", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);
    e_sel = 1'b0;
    e_ext = 1'b1;

    // CALL interrupted by reset during M3, checked before the next clock edge
    step("call_fetch", 1, 8'hCD, 0, 0, 0, 3'd0, 0, 0, 0);
    dec(4'b1000, 0, 0, 0, 3'd5);
    step("call_m1", 0, 8'h00, 1, 0, 0, 3'd1, 1, 0, 0);
    step("call_m2", 0, 8'h00, 1, 0, 0, 3'd2, 1, 0, 0);
    step("call_m3", 0, 8'h00, 0, 0, 0, 3'd3, 1, 0, 0);
    nRST = 1'b0;
    dec(4'b0001, 0, 0, 0, 3'd1);
    step("rst_async", 0, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0);
    nRST = 1'b1;
    step("rst_idle", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);
    e_sel = 1'b1;
    step("rst_idle_8080", 0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0);
    e_sel = 1'b0;

    done = 1'b1;
    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/decode8seq.md
Name: decode8seq

Overview:
- Parametrised successor to the 8-bit instruction class decoder.
- Latches the opcode on the fetch strobe and decodes its class (ta/mv/al/sc), M-field (ld) and H-field (hd).
- Resolves the full 8085 machine-cycle count and steps a machine-cycle index in handshake with the bus unit.
- Handles conditional early termination and the halt state.
- Sits between the bus/timing unit and the control-word generator.

Parameters:
- MCW, 3, width of cycle-count/index outputs; must hold MAXM.
- MAXM, 5, largest machine-cycle count; table entries above MAXM saturate to MAXM.
- EXT8085, 1, 1 = RIM (0x20)/SIM (0x30) flagged via oEXT; 0 = 8080 mode, treated as NOP, oEXT held 0.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- inDI  in  8  opcode from data bus
- iFETCH  in  1  opcode valid, M1 opcode read complete
- iMDONE  in  1  bus unit finished current machine cycle
- iCOND  in  1  condition-true flag for conditional ops
- iINTR  in  1  interrupt/reset request, exits halt
- oCLS  out  4  one-hot class of latched opcode
- oLD  out  1  src field = 110 (memory)
- oHD  out  1  dst field = 110 (memory)
- oM  out  MCW  total machine cycles, unconditional maximum
- oMIDX  out  MCW  current machine cycle, 1-based; 0 when idle
- oBUSY  out  1  instruction in progress
- oLAST  out  1  current cycle is the final one
- oHALT  out  1  halted
- oEXT  out  1  RIM/SIM latched (EXT8085=1 only)

Behaviour:
- One clock. nRST asynchronous active-low. The polarity and synchronicity are fixed.
- Reset values:
  - Opcode register = 0x00.
  - oMIDX = 0, oCLS = 4'b0001, oM = 1.
  - oLD, oHD, oBUSY, oLAST, oHALT, oEXT = 0.
  - State = IDLE.
- Class decode: ta = 00xxxxxx, mv = 01xxxxxx, al = 10xxxxxx, sc = 11xxxxxx. ld = i2..i0 == 110; hd = i5..i3 == 110.
- Decode outputs are registered from the latched opcode, so they are valid the cycle after iFETCH.
- Cycle table, first match wins:
  - mv: 0x76 HLT = 2; ld xor hd = 2; else 1.
  - al: ld = 2; else 1.
  - ta:
    - 0x36 = 3; 0x34/0x35 = 3.
    - 0x3A/0x32 = 4; 0x2A/0x22 = 5.
    - xx0001 LXI = 3; xx1001 DAD = 3.
    - 0x02/0x12/0x0A/0x1A = 2.
    - ld (MVI r) = 2; else 1.
  - sc:
    - 0xC3 = 3; 0xCD = 5; 0xC9 = 3; 0xE3 = 5.
    - 0xDB/0xD3 = 3.
    - xx0101 PUSH = 3; xx0001 POP = 3; xx111 RST = 3.
    - xx010 Jcc = 3; xx100 Ccc = 5; xx000 Rcc = 3.
    - ld = 2; else 1.
- Conditional ops and their check cycle:
  - Rcc: iCOND sampled at iMDONE of M1.
  - Jcc/Ccc: iCOND sampled at iMDONE of M2.
  - If iCOND = 0 at the check cycle, the instruction terminates there.
- FSM state IDLE:
  - oMIDX = 0.
  - On iFETCH: latch inDI, oMIDX = 1, go to RUN.
- FSM state RUN:
  - oBUSY = 1.
  - oLAST = (oMIDX == oM) or (check cycle and iCOND == 0); combinational.
  - On iMDONE with oLAST = 0: oMIDX++.
  - On iMDONE with oLAST = 1 and opcode 0x76: go to HALTED.
  - On iMDONE with oLAST = 1 and any other opcode: go to IDLE, oMIDX = 0.
  - If iFETCH coincides with that last iMDONE (back-to-back): latch the new opcode, oMIDX = 1, stay in RUN.
- FSM state HALTED:
  - oHALT = 1, oBUSY = 0, oMIDX = 0.
  - iFETCH ignored.
  - iINTR high for one clock -> IDLE.
- Priority and corner cases:
  - iFETCH in RUN without iMDONE on the last cycle: ignored, opcode unchanged.
  - iMDONE in IDLE/HALTED: ignored.
  - iCOND outside the check cycle: don't care.
  - nRST mid-instruction: immediate return to reset values.
- oMIDX never exceeds oM and never wraps.

Decomposition:
- Shared package holds:
  - Class encodings CLS_TA/MV/AL/SC.
  - FSM state constants IDLE/RUN/HALTED.
  - Opcode constants HLT, CALL, RET, JMP, XTHL, LDA, STA, LHLD, SHLD, IN, OUT, RIM, SIM.
  - Field constant FLD_M = 3'b110.
- One sub-module, decode8cnt: purely combinational opcode -> {class, ld, hd, count, is_cond, check_idx}, parametrised by MCW/MAXM/EXT8085.
- The top level holds the opcode register and the FSM.

Test Plan:
- 0x47 MOV B,A, iFETCH then iMDONE: oM = 1, oMIDX = 1, oLAST = 1, back to IDLE, oMIDX = 0; oCLS = 0010.
- 0x2A LHLD, 5 iMDONE pulses: oMIDX steps 1..5, oLAST only at 5, oBUSY drops after the fifth.
- 0xCC CZ:
  - iCOND = 0 at M2: terminates after 2 cycles.
  - iCOND = 1: runs 5 cycles.
  - 0xC8 RZ with iCOND = 0 at M1: single cycle.
- 0x76 HLT, 2 iMDONE pulses: oHALT = 1; iFETCH ignored; iINTR -> IDLE with oHALT = 0.
- Back-to-back: iFETCH 0x3E arrives with the last iMDONE of 0x21 LXI: new opcode latched, oMIDX = 1, oM = 2, no IDLE cycle.
- nRST low during M3 of 0xCD CALL: all outputs go to reset values asynchronously. EXT8085 = 0 with 0x20: oEXT = 0, oM = 1.
